// File: rtl/fp_div_arb.sv
// -----------------------------------------------------------------------------
// fp_div_arb_pkg / fp_div_arb
//
// Purpose:
//   Round-robin arbiter and sequencer that shares one multi-cycle fp_div
//   instance between NUM_REQ requesters.
//   - An op is accepted over a per-requester valid/ready handshake.
//   - The operands are registered and the divider gets a one-cycle start
//     pulse.
//   - The unrounded result and the divide-by-zero flag are captured on the
//     divider's done.
//   - They are returned, tagged with the requester ID and rounding mode, over
//     a valid/ready response channel.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   req_valid_i/req_ready_o  per-requester handshake (ready is one-hot or 0)
//   req_a_i/req_b_i          packed operands, slice i belongs to requester i
//   req_rnd_i                packed 3-bit rounding modes per requester
//   div_a_o/div_b_o          registered operands to fp_div
//   div_rnd_o                registered rounding mode to fp_div
//   div_start_o              one-cycle start pulse to fp_div
//   div_done_i               done from fp_div
//   div_result_i, div_dz_i   unrounded result bundle and divide-by-zero flag
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_result_o, rsp_dz_o   captured result bundle and divide-by-zero flag
//   rsp_rnd_o, rsp_id_o      rounding mode and requester index of the op
//   busy_o                   high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
package fp_div_arb_pkg;

  typedef enum logic [1:0] {
    FP16 = 2'd0,
    FP32 = 2'd1,
    FP64 = 2'd2
  } fp_format_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP16:    return 16;
      FP64:    return 64;
      default: return 32;
    endcase
  endfunction

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } roundmode_e;

  // Unrounded divider output for the FP32 datapath: truncated result plus
  // guard/round/sticky bits for the downstream rounder.
  typedef struct packed {
    logic [31:0] u_result;
    logic        guard;
    logic        round;
    logic        sticky;
  } uround_res_t;

endpackage

module fp_div_arb
  import fp_div_arb_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT = FP32,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned RES_WIDTH = $bits(uround_res_t),
  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT),
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*FP_WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*FP_WIDTH-1:0]   req_b_i,
  input  logic [NUM_REQ*3-1:0]          req_rnd_i,
  output logic [FP_WIDTH-1:0]           div_a_o,
  output logic [FP_WIDTH-1:0]           div_b_o,
  output logic [2:0]                    div_rnd_o,
  output logic                          div_start_o,
  input  logic                          div_done_i,
  input  logic [RES_WIDTH-1:0]          div_result_i,
  input  logic                          div_dz_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [RES_WIDTH-1:0]          rsp_result_o,
  output logic                          rsp_dz_o,
  output logic [2:0]                    rsp_rnd_o,
  output logic [ID_WIDTH-1:0]           rsp_id_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                state_q,      state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q,     rr_ptr_d;
  logic [FP_WIDTH-1:0]   div_a_q,      div_a_d;
  logic [FP_WIDTH-1:0]   div_b_q,      div_b_d;
  logic [2:0]            div_rnd_q,    div_rnd_d;
  logic [RES_WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic                  rsp_dz_q,     rsp_dz_d;
  logic [2:0]            rsp_rnd_q,    rsp_rnd_d;
  logic [ID_WIDTH-1:0]   rsp_id_q,     rsp_id_d;

  logic                  grant_valid;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [FP_WIDTH-1:0]   sel_a;
  logic [FP_WIDTH-1:0]   sel_b;
  logic [2:0]            sel_rnd;

  // Round-robin pick: the first pass only looks at requesters at or above the
  // pointer, the second pass wraps around to the low indices. Purely a
  // function of the valids and the pointer, so valid never waits on ready.
  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req_valid_i[i] && (ID_WIDTH'(i) >= rr_ptr_q)) begin
        grant_valid = 1'b1;
        grant_idx   = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && req_valid_i[i]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_WIDTH'(i);
      end
    end
  end

  // Operand mux and one-hot ready; ready is only offered while idle.
  always_comb begin
    sel_a       = '0;
    sel_b       = '0;
    sel_rnd     = '0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        sel_a   = req_a_i[i*FP_WIDTH +: FP_WIDTH];
        sel_b   = req_b_i[i*FP_WIDTH +: FP_WIDTH];
        sel_rnd = req_rnd_i[i*3 +: 3];
      end
      req_ready_o[i] = (state_q == IDLE) && grant_valid
                       && (grant_idx == ID_WIDTH'(i));
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_rnd_d    = div_rnd_q;
    rsp_result_d = rsp_result_q;
    rsp_dz_d     = rsp_dz_q;
    rsp_rnd_d    = rsp_rnd_q;
    rsp_id_d     = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          div_a_d   = sel_a;
          div_b_d   = sel_b;
          div_rnd_d = sel_rnd;
          rsp_rnd_d = sel_rnd;
          rsp_id_d  = grant_idx;
          rr_ptr_d  = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                             : grant_idx + ID_WIDTH'(1);
          state_d   = ISSUE;
        end
      end
      // The start pulse lives in this state; a done here cannot belong to
      // this op yet and is ignored.
      ISSUE: state_d = BUSY;
      BUSY: begin
        if (div_done_i) begin
          rsp_result_d = div_result_i;
          rsp_dz_d     = div_dz_i;
          state_d      = RESP;
        end
      end
      // Captured response is held until the consumer takes it; a stray done
      // here changes nothing.
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: the datapath registers are reset as well because they drive
      // output ports directly and must read 0 out of reset.
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_rnd_q    <= '0;
      rsp_result_q <= '0;
      rsp_dz_q     <= 1'b0;
      rsp_rnd_q    <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_rnd_q    <= div_rnd_d;
      rsp_result_q <= rsp_result_d;
      rsp_dz_q     <= rsp_dz_d;
      rsp_rnd_q    <= rsp_rnd_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // Control outputs decode straight from the state register, so they are
  // glitch-free and drop the cycle after a reset.
  assign div_start_o  = (state_q == ISSUE);
  assign rsp_valid_o  = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);

  assign div_a_o      = div_a_q;
  assign div_b_o      = div_b_q;
  assign div_rnd_o    = div_rnd_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_dz_o     = rsp_dz_q;
  assign rsp_rnd_o    = rsp_rnd_q;
  assign rsp_id_o     = rsp_id_q;

endmodule

// File: tb/tb_fp_div_arb.sv
// -----------------------------------------------------------------------------
// tb_fp_div_arb
//
// Self-checking bench for fp_div_arb with NUM_REQ=2, FP32. A small divider
// model stands in for fp_div: it answers DIV_LAT cycles after the start pulse
// with results for a handful of known operand pairs. Directed vectors are
// applied from a table. Hand-written sequences then cover:
//   - contention between both requesters,
//   - response backpressure,
//   - reset while the divider is busy,
//   - spurious done pulses.
// -----------------------------------------------------------------------------
module tb_fp_div_arb;
  import fp_div_arb_pkg::*;

  localparam int NUM_REQ   = 2;
  localparam int FP_WIDTH  = 32;
  localparam int RES_WIDTH = $bits(uround_res_t);
  localparam int ID_WIDTH  = 1;
  localparam int DIV_LAT   = 4;

  logic                        clk_i;
  logic                        reset_i;
  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic [NUM_REQ*FP_WIDTH-1:0] req_a_i;
  logic [NUM_REQ*FP_WIDTH-1:0] req_b_i;
  logic [NUM_REQ*3-1:0]        req_rnd_i;
  logic [FP_WIDTH-1:0]         div_a_o;
  logic [FP_WIDTH-1:0]         div_b_o;
  logic [2:0]                  div_rnd_o;
  logic                        div_start_o;
  logic                        div_done_i;
  logic [RES_WIDTH-1:0]        div_result_i;
  logic                        div_dz_i;
  logic                        rsp_valid_o;
  logic                        rsp_ready_i;
  logic [RES_WIDTH-1:0]        rsp_result_o;
  logic                        rsp_dz_o;
  logic [2:0]                  rsp_rnd_o;
  logic [ID_WIDTH-1:0]         rsp_id_o;
  logic                        busy_o;

  fp_div_arb #(
    .FP_FORMAT(FP32),
    .NUM_REQ  (NUM_REQ)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_rnd_i   (req_rnd_i),
    .div_a_o     (div_a_o),
    .div_b_o     (div_b_o),
    .div_rnd_o   (div_rnd_o),
    .div_start_o (div_start_o),
    .div_done_i  (div_done_i),
    .div_result_i(div_result_i),
    .div_dz_i    (div_dz_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_result_o(rsp_result_o),
    .rsp_dz_o    (rsp_dz_o),
    .rsp_rnd_o   (rsp_rnd_o),
    .rsp_id_o    (rsp_id_o),
    .busy_o      (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cnt = 0;
  bit spurious_done = 1'b0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (div_start_o) start_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference quotient for the operand pairs used below; returns
  // {u_result, guard, round, sticky, divide_by_zero}.
  function automatic logic [RES_WIDTH:0] ref_div(input logic [31:0] a,
                                                 input logic [31:0] b);
    if (b[30:0] == 31'd0) begin
      if (a[30:0] == 31'd0) return {32'h7FC00000, 3'b000, 1'b0};
      return {a[31] ^ b[31], 31'h7F800000, 3'b000, 1'b1};
    end
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return {32'h3F000000, 3'b000, 1'b0};
      {32'h40C00000, 32'h40000000}: return {32'h40400000, 3'b000, 1'b0};
      {32'h3F800000, 32'h40400000}: return {32'h3EAAAAAA, 3'b101, 1'b0};
      default:                      return '0;
    endcase
  endfunction

  // Divider model: evaluates 1 time unit after each falling edge, so all
  // inputs driven on that edge have settled. Done is raised in the cycle that
  // lies DIV_LAT cycles after the start cycle.
  initial begin
    int unsigned cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    cnt          = 0;
    op_a         = '0;
    op_b         = '0;
    div_done_i   = 1'b0;
    div_result_i = '0;
    div_dz_i     = 1'b0;
    forever begin
      @(negedge clk_i);
      #1;
      div_done_i = 1'b0;
      if (reset_i) begin
        cnt = 0;
      end else if (div_start_o) begin
        cnt  = DIV_LAT;
        op_a = div_a_o;
        op_b = div_b_o;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          div_done_i = 1'b1;
          {div_result_i, div_dz_i} = ref_div(op_a, op_b);
        end
      end
      if (spurious_done) begin
        div_done_i   = 1'b1;
        div_result_i = {32'hDEADBEEF, 3'b111};
        div_dz_i     = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive_req(input int r, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] rnd);
    if (r == 0) begin
      req_valid_i[0]  = v;
      req_a_i[31:0]   = a;
      req_b_i[31:0]   = b;
      req_rnd_i[2:0]  = rnd;
    end else begin
      req_valid_i[1]  = v;
      req_a_i[63:32]  = a;
      req_b_i[63:32]  = b;
      req_rnd_i[5:3]  = rnd;
    end
  endtask

  // Called #1 after a falling edge; returns with the grant visible in the
  // current cycle, or ok=0 after a bounded wait.
  task automatic wait_ready(input int r, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (req_ready_o[r == 0 ? 0 : 1]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rnd;
    logic [31:0] exp_u;
    logic [2:0]  exp_grs;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int acc;
    int s0;
    int g_req[4];
    int g_cyc[4];
    int r_ids[4];
    int gn;
    int rn;
    bit saw_rsp;

    vecs[0] = '{0, 32'h3F800000, 32'h40000000, 3'd0, 32'h3F000000, 3'b000, 1'b0};
    vecs[1] = '{1, 32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 3'b000, 1'b1};
    vecs[2] = '{1, 32'h40C00000, 32'h40000000, 3'd1, 32'h40400000, 3'b000, 1'b0};
    vecs[3] = '{0, 32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAA, 3'b101, 1'b0};
    vecs[4] = '{0, 32'hBF800000, 32'h00000000, 3'd2, 32'hFF800000, 3'b000, 1'b1};
    vecs[5] = '{1, 32'h00000000, 32'h00000000, 3'd4, 32'h7FC00000, 3'b000, 1'b0};

    reset_i     = 1'b1;
    rsp_ready_i = 1'b1;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    req_rnd_i   = '0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk_i);
    check("reset_ctrl", 64'({busy_o, rsp_valid_o, div_start_o, req_ready_o}), 64'd0);
    check("reset_div_regs", 64'({div_a_o, div_b_o, div_rnd_o}), 64'd0);
    check("reset_rsp_regs", 64'({rsp_result_o, rsp_dz_o, rsp_rnd_o, rsp_id_o}), 64'd0);
    reset_i = 1'b0;

    // ---------------- table-driven single ops ----------------
    foreach (vecs[k]) begin
      @(negedge clk_i);
      s0 = start_cnt;
      drive_req(vecs[k].req, 1'b1, vecs[k].a, vecs[k].b, vecs[k].rnd);
      #1;
      wait_ready(vecs[k].req, ok);
      check($sformatf("v%0d_accept", k), 64'(ok), 64'd1);
      acc = cyc;
      @(negedge clk_i);
      drive_req(vecs[k].req, 1'b0, vecs[k].a, vecs[k].b, vecs[k].rnd);
      check($sformatf("v%0d_start_at_accept_plus1", k), 64'(div_start_o), 64'd1);
      check($sformatf("v%0d_div_operands", k), 64'({div_a_o, div_b_o}),
            {vecs[k].a, vecs[k].b});
      wait_rsp(ok);
      check($sformatf("v%0d_rsp_seen", k), 64'(ok), 64'd1);
      check($sformatf("v%0d_latency", k), 64'(cyc - acc), 64'(2 + DIV_LAT));
      check($sformatf("v%0d_rsp_result", k), 64'(rsp_result_o),
            64'({vecs[k].exp_u, vecs[k].exp_grs}));
      check($sformatf("v%0d_rsp_tag", k), 64'({rsp_dz_o, rsp_rnd_o, rsp_id_o}),
            64'({vecs[k].exp_dz, vecs[k].rnd, vecs[k].req[0]}));
      @(negedge clk_i);
      check($sformatf("v%0d_back_idle", k), 64'({busy_o, rsp_valid_o}), 64'd0);
      check($sformatf("v%0d_one_start", k), 64'(start_cnt - s0), 64'd1);
    end

    // ---------------- contention, pointer starts at 0 after reset --------
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    drive_req(0, 1'b1, 32'h3F800000, 32'h40000000, 3'd0);
    drive_req(1, 1'b1, 32'h40C00000, 32'h40000000, 3'd1);
    #1;
    gn = 0;
    rn = 0;
    for (int n = 0; n < 100 && gn < 4; n++) begin
      if (rsp_valid_o && rn < 4) begin
        r_ids[rn] = int'(rsp_id_o);
        rn++;
      end
      if (req_ready_o != '0) begin
        check("cont_ready_onehot", 64'($onehot(req_ready_o)), 64'd1);
        g_req[gn] = req_ready_o[1] ? 1 : 0;
        g_cyc[gn] = cyc;
        gn++;
      end
      if (gn < 4) begin
        @(negedge clk_i);
        #1;
      end
    end
    check("cont_grant_count", 64'(gn), 64'd4);
    @(negedge clk_i);
    drive_req(0, 1'b0, 32'h3F800000, 32'h40000000, 3'd0);
    drive_req(1, 1'b0, 32'h40C00000, 32'h40000000, 3'd1);
    for (int i = 0; i < 4 && i < gn; i++)
      check($sformatf("cont_grant%0d_req", i), 64'(g_req[i]), 64'(i % 2));
    for (int i = 0; i < 3 && i + 1 < gn; i++)
      check($sformatf("cont_interval%0d", i), 64'(g_cyc[i+1] - g_cyc[i]),
            64'(DIV_LAT + 3));
    check("cont_rsp_count", 64'(rn), 64'd3);
    for (int i = 0; i < 3 && i < rn; i++)
      check($sformatf("cont_rsp%0d_id", i), 64'(r_ids[i]), 64'(i % 2));
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("cont_drain", 64'(ok), 64'd1);

    // ---------------- backpressure with a stray done in RESP ----------------
    rsp_ready_i = 1'b0;
    @(negedge clk_i);
    drive_req(0, 1'b1, 32'h40C00000, 32'h40000000, 3'd1);
    #1;
    wait_ready(0, ok);
    check("bp_accept", 64'(ok), 64'd1);
    @(negedge clk_i);
    drive_req(0, 1'b0, 32'h40C00000, 32'h40000000, 3'd1);
    wait_rsp(ok);
    check("bp_rsp_seen", 64'(ok), 64'd1);
    drive_req(1, 1'b1, 32'h3F800000, 32'h40400000, 3'd3);
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk_i);
      spurious_done = (n == 4);
      #1;
      check($sformatf("bp_hold%0d", n),
            64'({rsp_valid_o, rsp_dz_o, rsp_id_o, rsp_rnd_o, req_ready_o, rsp_result_o}),
            64'({1'b1, 1'b0, 1'b0, 3'd1, 2'b00, 32'h40400000, 3'b000}));
    end
    spurious_done = 1'b0;
    rsp_ready_i   = 1'b1;
    @(negedge clk_i);
    check("bp_idle_after_ready", 64'({busy_o, rsp_valid_o, req_ready_o}), 64'(2'b10));
    drive_req(1, 1'b0, 32'h3F800000, 32'h40400000, 3'd3);

    // ---------------- reset while busy ----------------
    @(negedge clk_i);
    drive_req(0, 1'b1, 32'h3F800000, 32'h40000000, 3'd0);
    #1;
    wait_ready(0, ok);
    check("rst_accept", 64'(ok), 64'd1);
    @(negedge clk_i);
    drive_req(0, 1'b0, 32'h3F800000, 32'h40000000, 3'd0);
    check("rst_start", 64'(div_start_o), 64'd1);
    repeat (3) @(negedge clk_i);
    check("rst_busy_before", 64'(busy_o), 64'd1);
    reset_i = 1'b1;
    s0 = start_cnt;
    @(negedge clk_i);
    reset_i = 1'b0;
    check("rst_busy_after", 64'(busy_o), 64'd0);
    saw_rsp = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (rsp_valid_o) saw_rsp = 1'b1;
    end
    check("rst_no_rsp", 64'(saw_rsp), 64'd0);
    check("rst_no_start", 64'(start_cnt - s0), 64'd0);
    // Pointer was reset, so requester 0 wins with both asking.
    drive_req(0, 1'b1, 32'h3F800000, 32'h40000000, 3'd0);
    drive_req(1, 1'b1, 32'h3F800000, 32'h40000000, 3'd0);
    #1;
    check("rst_ptr_zero", 64'(req_ready_o), 64'(2'b01));
    drive_req(0, 1'b0, 32'h3F800000, 32'h40000000, 3'd0);
    drive_req(1, 1'b0, 32'h3F800000, 32'h40000000, 3'd0);

    // ---------------- spurious done in IDLE ----------------
    @(negedge clk_i);
    spurious_done = 1'b1;
    @(negedge clk_i);
    spurious_done = 1'b0;
    check("spur_idle1", 64'({busy_o, rsp_valid_o}), 64'd0);
    @(negedge clk_i);
    check("spur_idle2", 64'({busy_o, rsp_valid_o, div_start_o}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
